// File: rtl/pipelined_adder_sub_if.sv
// Operand/result handshake bundle for pipelined_adder_sub.
// master drives operands and out_ready; slave is the adder.
interface pipelined_adder_sub_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] ina;
  logic [WIDTH-1:0] inb;
  logic             c_in;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] SUM;
  logic             c_out;
  logic             ovf;

  modport master (
    output in_valid, ina, inb, c_in, sub, out_ready,
    input  in_ready, out_valid, SUM, c_out, ovf
  );

  modport slave (
    input  in_valid, ina, inb, c_in, sub, out_ready,
    output in_ready, out_valid, SUM, c_out, ovf
  );
endinterface

// File: rtl/pipelined_adder_sub.sv
// Pipelined two's-complement adder/subtractor: one SEG_W-bit segment per stage,
// carry registered between stages, global stall from the output handshake.
module pipelined_adder_sub #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SEG_W = 8
) (
  input logic                  clk,
  input logic                  rst,
  pipelined_adder_sub_if.slave bus
);
  localparam int unsigned NSEG = WIDTH / SEG_W;

  if ((WIDTH % SEG_W) != 0) begin : g_param_err
    $error("pipelined_adder_sub: WIDTH must be a multiple of SEG_W");
  end

  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  always_comb begin
    b_eff   = bus.inb ^ {WIDTH{bus.sub}};
    cin_eff = bus.sub | bus.c_in;
  end

  assign advance      = ~bus.out_valid | bus.out_ready;
  assign bus.in_ready = advance;

  for (genvar k = 0; k < NSEG; k++) begin : g_stg
    // Operand B still to be consumed: segments k..NSEG-1, current segment at bit 0.
    localparam int unsigned BW = WIDTH - k * SEG_W;

    logic             in_v;
    logic             in_c;
    logic [WIDTH-1:0] in_a;
    logic [BW-1:0]    in_b;

    if (k == 0) begin : g_src
      assign in_v = bus.in_valid;
      assign in_c = cin_eff;
      assign in_a = bus.ina;
      assign in_b = b_eff;
    end else begin : g_src
      assign in_v = g_stg[k-1].v_q;
      assign in_c = g_stg[k-1].c_q;
      assign in_a = g_stg[k-1].a_q;
      assign in_b = g_stg[k-1].g_fwd.b_q;
    end

    logic [SEG_W:0]   seg_sum;
    logic             v_q, v_d;
    logic             c_q, c_d;
    // Segments 0..k hold finished sum bits, segments above still hold operand A.
    logic [WIDTH-1:0] a_q, a_d;

    assign seg_sum = {1'b0, in_a[k*SEG_W +: SEG_W]} + {1'b0, in_b[SEG_W-1:0]}
                   + (SEG_W+1)'(in_c);

    always_comb begin
      v_d = v_q;
      c_d = c_q;
      a_d = a_q;
      if (rst) begin
        v_d = 1'b0;
        c_d = 1'b0;
        a_d = '0;
      end else if (advance) begin
        v_d                    = in_v;
        c_d                    = seg_sum[SEG_W];
        a_d                    = in_a;
        a_d[k*SEG_W +: SEG_W]  = seg_sum[SEG_W-1:0];
      end
    end

    always_ff @(posedge clk) begin
      v_q <= v_d;
      c_q <= c_d;
      a_q <= a_d;
    end

    if (k < NSEG - 1) begin : g_fwd
      logic [BW-SEG_W-1:0] b_q, b_d;

      always_comb begin
        b_d = b_q;
        if (rst) begin
          b_d = '0;
        end else if (advance) begin
          b_d = in_b[BW-1:SEG_W];
        end
      end

      always_ff @(posedge clk) begin
        b_q <= b_d;
      end
    end else begin : g_last
      logic ovf_q, ovf_d;
      logic msb_cin;

      // Carry into the MSB recovered from the MSB sum bit and its two inputs.
      assign msb_cin = in_a[WIDTH-1] ^ in_b[SEG_W-1] ^ seg_sum[SEG_W-1];

      always_comb begin
        ovf_d = ovf_q;
        if (rst) begin
          ovf_d = 1'b0;
        end else if (advance) begin
          ovf_d = msb_cin ^ seg_sum[SEG_W];
        end
      end

      always_ff @(posedge clk) begin
        ovf_q <= ovf_d;
      end

      assign bus.out_valid = v_q;
      assign bus.SUM       = a_q;
      assign bus.c_out     = c_q;
      assign bus.ovf       = ovf_q;
    end
  end
endmodule
